wakeup_broadcast: RTL and testbench

Parametrised physical-register wakeup unit between the execution-unit select logic and the issue queues. Each of NUM_CH execution channels gets a destination-PR broadcast, delayed by a fixed per-channel latency: 0 for speculative same-cycle wakeup, N for pipelined units. It also holds a per-PR ready (busy) table that the rename/dispatch stage queries and the broadcasts clear. A flush kills all in-flight delayed wakeups.

---
 rtl/wakeup_broadcast_if.sv | 33 +++
 rtl/wakeup_broadcast.sv | 124 ++++++++++++
 tb/tb_wakeup_broadcast.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wakeup_broadcast_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wakeup_broadcast_if                                           |
// | Brief    : Issue, wakeup, allocation and ready-query bundle.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface wakeup_broadcast_if #(
    parameter int NUM_CH    = 4,
    parameter int PR_W      = 6,
    parameter int NUM_ALLOC = 2,
    parameter int NUM_RD    = 4
);
    logic                      flush;
    logic [NUM_CH-1:0]         issue_vld;
    logic [NUM_CH*PR_W-1:0]    issue_pr;
    logic [NUM_CH-1:0]         wake_vld;
    logic [NUM_CH*PR_W-1:0]    wake_pr;
    logic [NUM_ALLOC-1:0]      alloc_vld;
    logic [NUM_ALLOC*PR_W-1:0] alloc_pr;
    logic [NUM_RD*PR_W-1:0]    rd_pr;
    logic [NUM_RD-1:0]         rd_ready;

    modport master (
        output flush, issue_vld, issue_pr, alloc_vld, alloc_pr, rd_pr,
        input  wake_vld, wake_pr, rd_ready
    );

    modport slave (
        input  flush, issue_vld, issue_pr, alloc_vld, alloc_pr, rd_pr,
        output wake_vld, wake_pr, rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/wakeup_broadcast.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wakeup_broadcast                                              |
// | Brief    : Per-channel delayed PR wakeup broadcast plus PR ready table.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module wakeup_broadcast #(
    parameter int                      NUM_CH    = 4,
    parameter int                      PR_W      = 6,
    parameter int                      LAT_W     = 2,
    parameter logic [NUM_CH*LAT_W-1:0] CH_LAT    = '0,
    parameter int                      NUM_ALLOC = 2,
    parameter int                      NUM_RD    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    wakeup_broadcast_if.slave bus
);
    localparam int c_NUM_PR = 1 << PR_W;

    logic [PR_W-1:0] w_issue_pr   [NUM_CH];
    logic            w_issue_take [NUM_CH];
    logic            w_wake_vld   [NUM_CH];
    logic [PR_W-1:0] w_wake_pr    [NUM_CH];

    logic [c_NUM_PR-1:0] ready_q;
    logic [c_NUM_PR-1:0] ready_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int c_LAT = int'(CH_LAT[i*LAT_W +: LAT_W]);

        assign w_issue_pr[i] = bus.issue_pr[i*PR_W +: PR_W];
        // PR 0 means "no destination", so it never enters the wakeup path.
        assign w_issue_take[i] = bus.issue_vld[i] & ~bus.flush & (w_issue_pr[i] != '0);

        if (c_LAT == 0) begin : g_comb
            assign w_wake_vld[i] = w_issue_take[i];
            assign w_wake_pr[i]  = w_issue_take[i] ? w_issue_pr[i] : '0;
        end else begin : g_pipe
            logic [c_LAT-1:0] vld_q;
            logic [c_LAT-1:0] vld_d;
            logic [PR_W-1:0]  pr_q [c_LAT];
            logic [PR_W-1:0]  pr_d [c_LAT];

            always_comb begin
                vld_d[0] = w_issue_take[i];
                pr_d[0]  = w_issue_take[i] ? w_issue_pr[i] : '0;
                for (int s = 1; s < c_LAT; s++) begin
                    vld_d[s] = vld_q[s-1] & ~bus.flush;
                    pr_d[s]  = vld_q[s-1] ? pr_q[s-1] : '0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int s = 0; s < c_LAT; s++) begin
                        pr_q[s] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int s = 0; s < c_LAT; s++) begin
                        pr_q[s] <= pr_d[s];
                    end
                end
            end

            assign w_wake_vld[i] = vld_q[c_LAT-1] & ~bus.flush;
            assign w_wake_pr[i]  = w_wake_vld[i] ? pr_q[c_LAT-1] : '0;
        end
    end

    always_comb begin
        bus.wake_vld = '0;
        bus.wake_pr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.wake_vld[i]               = w_wake_vld[i];
            bus.wake_pr[i*PR_W +: PR_W]   = w_wake_pr[i];
        end
    end

    // Allocation is applied after wakeups so it wins on a same-PR collision.
    always_comb begin
        ready_d = ready_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wake_vld[i]) begin
                ready_d[w_wake_pr[i]] = 1'b1;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (bus.alloc_vld[a]) begin
                ready_d[bus.alloc_pr[a*PR_W +: PR_W]] = 1'b0;
            end
        end
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= '1;
        end else begin
            ready_q <= ready_d;
        end
    end

    always_comb begin : p_rd
        logic [PR_W-1:0] w_rd_pr;
        logic            w_hit;
        w_rd_pr      = '0;
        w_hit        = 1'b0;
        bus.rd_ready = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_pr = bus.rd_pr[k*PR_W +: PR_W];
            w_hit   = ready_q[w_rd_pr];
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wake_vld[i] && (w_wake_pr[i] == w_rd_pr)) begin
                    w_hit = 1'b1;
                end
            end
            bus.rd_ready[k] = w_hit;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wakeup_broadcast.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wakeup_broadcast                                           |
// | Brief    : Directed scoreboard bench for wakeup_broadcast.               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_wakeup_broadcast;
    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int val;
    } exp_t;

    exp_t sb[$];

    wakeup_broadcast_if #(.NUM_CH(4), .PR_W(6), .NUM_ALLOC(2), .NUM_RD(4)) bus ();

    // ch0 L=2, ch1 L=1, ch2 L=0, ch3 L=0
    wakeup_broadcast #(
        .NUM_CH(4), .PR_W(6), .LAT_W(2), .CH_LAT(8'b00_00_01_10),
        .NUM_ALLOC(2), .NUM_RD(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        bus.flush     = 1'b0;
        bus.issue_vld = '0;
        bus.issue_pr  = '0;
        bus.alloc_vld = '0;
        bus.alloc_pr  = '0;
    endtask

    task automatic iss(int ch, int pr);
        bus.issue_vld[ch]       = 1'b1;
        bus.issue_pr[ch*6 +: 6] = 6'(pr);
    endtask

    task automatic alc(int port, int pr);
        bus.alloc_vld[port]       = 1'b1;
        bus.alloc_pr[port*6 +: 6] = 6'(pr);
    endtask

    task automatic exp_wake(int c, int ch, int pr);
        sb.push_back('{c, 0, ch, pr});
    endtask

    task automatic exp_rd(int c, int k, int v);
        sb.push_back('{c, 1, k, v});
    endtask

    // Monitor: every channel is checked every cycle; unexpected wakes are errors.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int ch = 0; ch < 4; ch++) begin
                int         hit;
                logic [5:0] got_pr;
                hit    = -1;
                got_pr = bus.wake_pr[ch*6 +: 6];
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].cyc == cyc && sb[j].kind == 0 && sb[j].idx == ch) hit = j;
                end
                total++;
                if (hit >= 0) begin
                    if (bus.wake_vld[ch] !== 1'b1 || got_pr !== 6'(sb[hit].val)) begin
                        bad++;
                        $display("FAIL wake ch%0d cyc=%0d: got vld=%b pr=%0d, want vld=1 pr=%0d",
                                 ch, cyc, bus.wake_vld[ch], got_pr, sb[hit].val);
                    end
                    sb.delete(hit);
                end else if (bus.wake_vld[ch] !== 1'b0 || got_pr !== 6'd0) begin
                    bad++;
                    $display("FAIL idle ch%0d cyc=%0d: got vld=%b pr=%0d, want vld=0 pr=0",
                             ch, cyc, bus.wake_vld[ch], got_pr);
                end
            end
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].cyc == cyc && sb[j].kind == 1) begin
                    total++;
                    if (bus.rd_ready[sb[j].idx] !== sb[j].val[0]) begin
                        bad++;
                        $display("FAIL rd_ready[%0d] cyc=%0d pr=%0d: got %b, want %0d",
                                 sb[j].idx, cyc, bus.rd_pr[sb[j].idx*6 +: 6],
                                 bus.rd_ready[sb[j].idx], sb[j].val);
                    end
                    sb.delete(j);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr();
        bus.rd_pr = {6'd4, 6'd0, 6'd12, 6'd7};
        for (int k = 0; k < 4; k++) exp_rd(1, k, 1);

        at(2);  rst_n = 1'b1;
        at(3);  alc(0, 7); alc(1, 4);
                exp_rd(3, 0, 1); exp_rd(3, 3, 1);
        at(4);  clr(); exp_rd(4, 0, 0); exp_rd(4, 3, 0);
        at(5);  iss(0, 4); exp_rd(5, 3, 0);
        at(6);  clr(); bus.flush = 1'b1; iss(3, 20);
        at(7);  clr(); exp_rd(7, 0, 0); exp_rd(7, 3, 0);
        at(8);  iss(2, 7); exp_wake(8, 2, 7);
                exp_rd(8, 0, 1); exp_rd(8, 3, 0);
        at(9);  clr(); exp_rd(9, 0, 1); exp_rd(9, 3, 0);
        at(10); iss(0, 5); iss(3, 9); iss(1, 11);
                exp_wake(10, 3, 9); exp_wake(11, 1, 11); exp_wake(12, 0, 5);
        at(11); clr(); iss(1, 11); exp_wake(12, 1, 11); exp_rd(11, 0, 1);
        at(12); clr(); exp_rd(12, 3, 0);
        at(14); alc(0, 12); iss(3, 12); exp_wake(14, 3, 12); exp_rd(14, 1, 1);
        at(15); clr(); exp_rd(15, 1, 0);
        at(16); for (int ch = 0; ch < 4; ch++) iss(ch, 0);
                alc(0, 0); alc(1, 0);
                exp_rd(16, 2, 1); exp_rd(16, 1, 0);
        at(17); clr(); exp_rd(17, 2, 1); exp_rd(17, 3, 0);
        at(18); alc(0, 30); bus.rd_pr[3*6 +: 6] = 6'd30;
                exp_rd(18, 2, 1); exp_rd(18, 3, 1);
        at(19); clr(); iss(0, 33); iss(1, 34); exp_rd(19, 3, 0);
        at(20); clr(); iss(0, 35); iss(1, 36); rst_n = 1'b0;
                exp_wake(20, 1, 34); exp_rd(20, 3, 0);
        at(21); clr();
                for (int k = 0; k < 4; k++) exp_rd(21, k, 1);
        at(22); rst_n = 1'b1;
        at(24); iss(1, 40); exp_wake(25, 1, 40);
        at(25); clr(); exp_rd(25, 1, 1);
        at(28);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
